// File: rtl/tx_gearbox_130b.sv
// TX 128b/130b gearbox: packs 2-bit sync header plus 16 symbols per block into a
// continuous byte stream (Gen3+), or registers symbols straight through (Gen1/2).
module tx_gearbox_130b #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int SYNC_WIDTH   = 2,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    tx_clk,
    input  logic                    tx_rst,
    input  logic                    GEN,
    input  logic [SYMBOL_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    Tx_Start_Block,
    input  logic [SYNC_WIDTH-1:0]   sync_header,
    output logic [SYMBOL_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    back_pressure,
    output logic                    framing_err
);

    localparam int BUF_W = 2 * SYMBOL_WIDTH;
    localparam int NEW_W = SYMBOL_WIDTH + SYNC_WIDTH;
    localparam int CMB_W = BUF_W + 1;

    logic [BUF_W-1:0]        buf_r, buf_nxt_s;
    logic [3:0]              fill_r, fill_nxt_s;
    logic [CNT_WIDTH-1:0]    sym_cnt_r, sym_cnt_nxt_s;
    logic                    started_r, started_nxt_s;
    logic                    gen_r;
    logic [SYMBOL_WIDTH-1:0] out_data_r, out_data_nxt_s;
    logic                    out_valid_r, out_valid_nxt_s;
    logic                    err_r, err_nxt_s;

    logic [NEW_W-1:0]        new_s;
    logic [CMB_W-1:0]        combined_s;
    logic [4:0]              total_s;
    logic                    bp_s;
    logic                    bad_start_s;
    logic                    bad_cont_s;

    // Stall whenever a full byte of residual bits is waiting to be drained.
    always_comb begin
        bp_s = GEN & (fill_r >= 4'd8);
    end

    // Merge the incoming symbol (with header on block start) above the residual bits.
    always_comb begin
        if (Tx_Start_Block) begin
            new_s   = {in_data, sync_header};
            total_s = {1'b0, fill_r} + 5'(NEW_W);
        end else begin
            new_s   = {{SYNC_WIDTH{1'b0}}, in_data};
            total_s = {1'b0, fill_r} + 5'(SYMBOL_WIDTH);
        end
        combined_s  = {1'b0, buf_r} | ({{(CMB_W-NEW_W){1'b0}}, new_s} << fill_r);
        // The very first block after reset or a mode change may start anywhere.
        bad_start_s = started_r & (sym_cnt_r != '0);
        bad_cont_s  = started_r & (sym_cnt_r == '0);
    end

    // Next-state selection: mode change, pass-through, drain, pack, or idle.
    always_comb begin
        buf_nxt_s       = buf_r;
        fill_nxt_s      = fill_r;
        sym_cnt_nxt_s   = sym_cnt_r;
        started_nxt_s   = started_r;
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = 1'b0;
        err_nxt_s       = err_r;
        if (GEN != gen_r) begin
            buf_nxt_s     = '0;
            fill_nxt_s    = 4'd0;
            sym_cnt_nxt_s = '0;
            started_nxt_s = 1'b0;
        end else if (!GEN) begin
            out_data_nxt_s  = in_data;
            out_valid_nxt_s = in_valid;
            buf_nxt_s       = '0;
            fill_nxt_s      = 4'd0;
            sym_cnt_nxt_s   = '0;
            started_nxt_s   = 1'b0;
        end else if (bp_s) begin
            out_data_nxt_s  = buf_r[SYMBOL_WIDTH-1:0];
            out_valid_nxt_s = 1'b1;
            buf_nxt_s       = buf_r >> SYMBOL_WIDTH;
            fill_nxt_s      = fill_r - 4'd8;
        end else if (in_valid) begin
            if (total_s >= 5'd8) begin
                out_data_nxt_s  = combined_s[SYMBOL_WIDTH-1:0];
                out_valid_nxt_s = 1'b1;
                buf_nxt_s       = BUF_W'(combined_s >> SYMBOL_WIDTH);
                fill_nxt_s      = 4'(total_s - 5'd8);
            end else begin
                out_valid_nxt_s = 1'b0;
                buf_nxt_s       = BUF_W'(combined_s);
                fill_nxt_s      = 4'(total_s);
            end
            if (Tx_Start_Block) begin
                sym_cnt_nxt_s = CNT_WIDTH'(1);
                started_nxt_s = 1'b1;
                err_nxt_s     = err_r | bad_start_s;
            end else begin
                sym_cnt_nxt_s = sym_cnt_r + CNT_WIDTH'(1);
                started_nxt_s = started_r;
                err_nxt_s     = err_r | bad_cont_s;
            end
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // State and output registers; GEN is tracked even in reset so release is not a mode change.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            buf_r       <= '0;
            fill_r      <= 4'd0;
            sym_cnt_r   <= '0;
            started_r   <= 1'b0;
            gen_r       <= GEN;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            buf_r       <= buf_nxt_s;
            fill_r      <= fill_nxt_s;
            sym_cnt_r   <= sym_cnt_nxt_s;
            started_r   <= started_nxt_s;
            gen_r       <= GEN;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign back_pressure = bp_s;
    assign framing_err   = err_r;

endmodule

// File: tb/tb_tx_gearbox_130b.sv
// Randomized self-checking bench for tx_gearbox_130b against a bit-queue stream model.
module tb_tx_gearbox_130b;

    logic       tx_clk = 1'b0;
    logic       tx_rst = 1'b1;
    logic       GEN = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       Tx_Start_Block = 1'b0;
    logic [1:0] sync_header = 2'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       back_pressure;
    logic       framing_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stall_cnt;
    int stall_sym;
    int sym_idx;
    bit mon_en = 1'b0;
    bit ref_q[$];
    logic [7:0] out_q[$];
    int out_cyc[$];

    tx_gearbox_130b dut (
        .tx_clk        (tx_clk),
        .tx_rst        (tx_rst),
        .GEN           (GEN),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .Tx_Start_Block(Tx_Start_Block),
        .sync_header   (sync_header),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .back_pressure (back_pressure),
        .framing_err   (framing_err)
    );

    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) cyc <= cyc + 1;

    always @(negedge tx_clk) begin
        if (mon_en && out_valid) begin
            out_q.push_back(out_data);
            out_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic do_reset();
        tx_rst = 1'b1;
        in_valid = 1'b0;
        Tx_Start_Block = 1'b0;
        repeat (2) tick();
        tx_rst = 1'b0;
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        Tx_Start_Block = 1'b0;
        tick();
    endtask

    // Present one symbol and hold it until accepted; the model records its bits.
    task automatic send_sym(input logic [7:0] d, input logic st, input logic [1:0] hdr);
        bit bp_seen;
        bit accepted = 1'b0;
        in_data = d;
        Tx_Start_Block = st;
        sync_header = hdr;
        in_valid = 1'b1;
        sym_idx++;
        for (int t = 0; t < 8 && !accepted; t++) begin
            bp_seen = back_pressure;
            tick();
            if (bp_seen) begin
                stall_cnt++;
                stall_sym = sym_idx;
            end else begin
                accepted = 1'b1;
            end
        end
        check_eq("send_accept", {31'd0, accepted}, 32'd1);
        if (st) begin
            ref_q.push_back(hdr[0]);
            ref_q.push_back(hdr[1]);
        end
        for (int b = 0; b < 8; b++) ref_q.push_back(d[b]);
    endtask

    task automatic send_block(input int nsym, input bit gaps);
        logic [1:0] hdr;
        hdr = 2'($urandom_range(0, 3));
        for (int s = 0; s < nsym; s++) begin
            if (gaps && $urandom_range(0, 3) == 0) go_idle();
            send_sym(8'($urandom), (s == 0), hdr);
        end
    endtask

    task automatic start_capture();
        ref_q.delete();
        out_q.delete();
        out_cyc.delete();
        stall_cnt = 0;
        stall_sym = 0;
        sym_idx = 0;
        mon_en = 1'b1;
    endtask

    task automatic check_stream(input string tag);
        int bad = 0;
        logic [7:0] exp_b;
        check_eq({tag, "_bits"}, 32'(out_q.size() * 8), 32'(ref_q.size()));
        for (int k = 0; k < out_q.size() && (k * 8 + 7) < ref_q.size(); k++) begin
            for (int b = 0; b < 8; b++) exp_b[b] = ref_q[k * 8 + b];
            if (out_q[k] !== exp_b) bad++;
        end
        check_eq({tag, "_bad_bytes"}, 32'(bad), 32'd0);
    endtask

    // Header FF/10 then 00 must give FE then 03.
    task automatic scenario_align(input string tag);
        send_sym(8'hFF, 1'b1, 2'b10);
        @(negedge tx_clk);
        check_eq({tag, "_b0"}, {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hFE});
        send_sym(8'h00, 1'b0, 2'b00);
        @(negedge tx_clk);
        check_eq({tag, "_b1"}, {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h03});
        go_idle();
    endtask

    initial begin
        GEN = 1'b1;
        do_reset();
        @(negedge tx_clk);
        check_eq("reset_outs", {20'd0, out_data, out_valid, back_pressure, framing_err}, 32'd0);

        scenario_align("align");

        // Four back-to-back blocks: one stall after block-4 start, 65 continuous bytes.
        do_reset();
        start_capture();
        for (int blk = 0; blk < 4; blk++) send_block(16, 1'b0);
        repeat (3) go_idle();
        mon_en = 1'b0;
        check_eq("cad_stalls", 32'(stall_cnt), 32'd1);
        check_eq("cad_stall_sym", 32'(stall_sym), 32'd50);
        check_eq("cad_bytes", 32'(out_q.size()), 32'd65);
        if (out_q.size() > 0)
            check_eq("cad_contig", 32'(out_cyc[out_q.size() - 1] - out_cyc[0] + 1), 32'd65);
        check_stream("cad_stream");
        check_eq("cad_no_err", {31'd0, framing_err}, 32'd0);

        // Random headers/data with input bubbles over 64 blocks.
        do_reset();
        start_capture();
        for (int blk = 0; blk < 64; blk++) send_block(16, 1'b1);
        repeat (3) go_idle();
        mon_en = 1'b0;
        check_stream("rnd_stream");
        check_eq("rnd_no_err", {31'd0, framing_err}, 32'd0);

        // Early block start at sym_cnt=5.
        do_reset();
        send_block(5, 1'b0);
        @(negedge tx_clk);
        check_eq("ferr_before", {31'd0, framing_err}, 32'd0);
        send_sym(8'h11, 1'b1, 2'b01);
        @(negedge tx_clk);
        check_eq("ferr_set", {31'd0, framing_err}, 32'd1);
        repeat (5) go_idle();
        check_eq("ferr_sticky", {31'd0, framing_err}, 32'd1);
        do_reset();
        @(negedge tx_clk);
        check_eq("ferr_cleared", {31'd0, framing_err}, 32'd0);

        // Missing block start after 16 symbols.
        send_block(16, 1'b0);
        @(negedge tx_clk);
        check_eq("ferr2_before", {31'd0, framing_err}, 32'd0);
        send_sym(8'h22, 1'b0, 2'b00);
        @(negedge tx_clk);
        check_eq("ferr2_set", {31'd0, framing_err}, 32'd1);
        go_idle();

        // Mode switch with residual bits (fill=6), pass-through, and back.
        do_reset();
        send_block(16, 1'b0);
        send_block(16, 1'b0);
        send_block(1, 1'b0);
        GEN = 1'b0;
        in_data = 8'h3C;
        in_valid = 1'b1;
        Tx_Start_Block = 1'b0;
        tick();
        @(negedge tx_clk);
        check_eq("sw_drop_valid", {31'd0, out_valid}, 32'd0);
        check_eq("sw_bp", {31'd0, back_pressure}, 32'd0);
        in_data = 8'hA5;
        tick();
        @(negedge tx_clk);
        check_eq("pass_a5", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA5});
        check_eq("pass_bp", {31'd0, back_pressure}, 32'd0);
        in_data = 8'h5A;
        in_valid = 1'b0;
        tick();
        @(negedge tx_clk);
        check_eq("pass_invalid", {31'd0, out_valid}, 32'd0);
        GEN = 1'b1;
        tick();
        @(negedge tx_clk);
        check_eq("sw_back_valid", {31'd0, out_valid}, 32'd0);
        scenario_align("sw_align");

        // Reset mid-operation at fill=4.
        do_reset();
        send_block(16, 1'b0);
        send_block(1, 1'b0);
        tx_rst = 1'b1;
        tick();
        @(negedge tx_clk);
        check_eq("midrst_outs", {20'd0, out_data, out_valid, back_pressure, framing_err}, 32'd0);
        tx_rst = 1'b0;
        in_valid = 1'b0;
        scenario_align("midrst_align");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
